// File: rtl/adder64_sequencer.sv
// rtl/adder64_sequencer.sv - 64-bit adder sequencer over one shared 32-bit adder; ADDSEQ_FLAGS_EN adds carry_o/ovf_o
module adder64_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2*DATA_W-1:0]   a_i,
  input  logic [2*DATA_W-1:0]   b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [2*DATA_W-1:0]   sum_o,
`ifdef ADDSEQ_FLAGS_EN
  output logic                  carry_o,
  output logic                  ovf_o,
`endif
  output logic                  busy_o,
  output logic [DATA_W-1:0]     add_a_o,
  output logic [DATA_W-1:0]     add_b_o,
  input  logic [DATA_W-1:0]     add_sum_i
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    INC  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [2*DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0]   sum_lo_q, sum_hi_q;
  logic                c_lo_q;
`ifdef ADDSEQ_FLAGS_EN
  logic                c_hi_q, c_inc_q;
`endif

  // State register; reset aborts whatever operation is in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and adder pin decode; adder is only driven in the three pass states
  always_comb begin
    state_d = state_q;
    add_a_o = '0;
    add_b_o = '0;
    case (state_q)
      IDLE: if (in_valid_i) state_d = LO;
      LO: begin
        add_a_o = a_q[DATA_W-1:0];
        add_b_o = b_q[DATA_W-1:0];
        state_d = HI;
      end
      HI: begin
        add_a_o = a_q[2*DATA_W-1:DATA_W];
        add_b_o = b_q[2*DATA_W-1:DATA_W];
        state_d = c_lo_q ? INC : DONE;
      end
      INC: begin
        add_a_o = sum_hi_q;
        add_b_o = {{(DATA_W-1){1'b0}}, 1'b1};
        state_d = DONE;
      end
      DONE: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and per-pass result/carry registers; carries derived by wrap-around compare
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q      <= '0;
      b_q      <= '0;
      sum_lo_q <= '0;
      sum_hi_q <= '0;
      c_lo_q   <= 1'b0;
`ifdef ADDSEQ_FLAGS_EN
      c_hi_q   <= 1'b0;
      c_inc_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          a_q <= a_i;
          b_q <= b_i;
        end
        LO: begin
          sum_lo_q <= add_sum_i;
          c_lo_q   <= (add_sum_i < a_q[DATA_W-1:0]);
        end
        HI: begin
          sum_hi_q <= add_sum_i;
`ifdef ADDSEQ_FLAGS_EN
          c_hi_q   <= (add_sum_i < a_q[2*DATA_W-1:DATA_W]);
          c_inc_q  <= 1'b0;
`endif
        end
        INC: begin
          sum_hi_q <= add_sum_i;
`ifdef ADDSEQ_FLAGS_EN
          c_inc_q  <= (sum_hi_q == {DATA_W{1'b1}});
`endif
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign sum_o       = {sum_hi_q, sum_lo_q};

`ifdef ADDSEQ_FLAGS_EN
  assign carry_o = out_valid_o & (c_hi_q | c_inc_q);
  assign ovf_o   = out_valid_o & (a_q[2*DATA_W-1] == b_q[2*DATA_W-1])
                               & (sum_hi_q[DATA_W-1] != a_q[2*DATA_W-1]);
`endif

endmodule

// File: tb/tb_adder64_sequencer.sv
// tb/tb_adder64_sequencer.sv - table-driven bench for adder64_sequencer with reset and backpressure sequences
module tb_adder64_sequencer;

  logic        clk_i;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] a_i, b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] sum_o;
  logic        busy_o;
  logic [31:0] add_a_o, add_b_o, add_sum_i;
`ifdef ADDSEQ_FLAGS_EN
  logic        carry_o, ovf_o;
`endif

  adder64_sequencer #(.DATA_W(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sum_o       (sum_o),
`ifdef ADDSEQ_FLAGS_EN
    .carry_o     (carry_o),
    .ovf_o       (ovf_o),
`endif
    .busy_o      (busy_o),
    .add_a_o     (add_a_o),
    .add_b_o     (add_b_o),
    .add_sum_i   (add_sum_i)
  );

  // Shared carry-less 32-bit adder
  assign add_sum_i = add_a_o + add_b_o;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] sum;
    int          lat;
    logic        carry;
    logic        ovf;
  } vec_t;

  vec_t  vecs [9];
  int    n_cmp = 0;
  int    n_bad = 0;
  string cur_tag = "";

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", cur_tag, name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready",  64'(in_ready_o),  64'd1);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_busy",      64'(busy_o),      64'd0);
    chk("rst_sum",       sum_o,            64'd0);
    chk("rst_add_a",     64'(add_a_o),     64'd0);
    chk("rst_add_b",     64'(add_b_o),     64'd0);
`ifdef ADDSEQ_FLAGS_EN
    chk("rst_carry",     64'(carry_o),     64'd0);
    chk("rst_ovf",       64'(ovf_o),       64'd0);
`endif
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] sum,
                        input int lat, input logic carry, input logic ovf, input string tag);
    int got;
    logic [31:0] hi_sum;
    cur_tag = tag;
    got = 0;
    hi_sum = a[63:32] + b[63:32];
    @(negedge clk_i);
    chk("in_ready", 64'(in_ready_o), 64'd1);
    a_i = a; b_i = b; in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      if (k == 1) begin
        chk("lo_add_a", 64'(add_a_o), 64'(a[31:0]));
        chk("lo_add_b", 64'(add_b_o), 64'(b[31:0]));
      end
      if (k == 2) begin
        chk("hi_add_a", 64'(add_a_o), 64'(a[63:32]));
        chk("hi_add_b", 64'(add_b_o), 64'(b[63:32]));
      end
      if (k == 3 && lat == 4) begin
        chk("inc_add_a", 64'(add_a_o), 64'(hi_sum));
        chk("inc_add_b", 64'(add_b_o), 64'd1);
      end
      if (out_valid_o) begin
        got = k;
        break;
      end
    end
    chk("latency", 64'(got), 64'(lat));
    if (got != 0) begin
      chk("sum",        sum_o,            sum);
      chk("done_busy",  64'(busy_o),      64'd1);
      chk("done_add_a", 64'(add_a_o),     64'd0);
      chk("done_ready", 64'(in_ready_o),  64'd0);
`ifdef ADDSEQ_FLAGS_EN
      chk("carry",      64'(carry_o),     64'(carry));
      chk("ovf",        64'(ovf_o),       64'(ovf));
`endif
      @(negedge clk_i);
      chk("post_valid", 64'(out_valid_o), 64'd0);
      chk("post_ready", 64'(in_ready_o),  64'd1);
      chk("post_busy",  64'(busy_o),      64'd0);
    end
  endtask

  initial begin
    int got;
    int seen;

    //            a                      b                      sum                    lat carry ovf
    vecs[0] = '{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_000C, 3, 1'b0, 1'b0};
    vecs[1] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0001_0000_0000, 4, 1'b0, 1'b0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 4, 1'b1, 1'b0};
    vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 4, 1'b0, 1'b1};
    vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h2222_2222_2222_2211, 4, 1'b0, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 3, 1'b1, 1'b1};
    vecs[6] = '{64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0000, 3, 1'b1, 1'b0};
    vecs[7] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 3, 1'b0, 1'b0};
    vecs[8] = '{64'h0000_0001_8000_0000, 64'h0000_0002_8000_0000, 64'h0000_0004_0000_0000, 4, 1'b0, 1'b0};

    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; a_i = '0; b_i = '0;
    cur_tag = "reset";
    #12;
    chk_reset_outputs();
    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].lat, vecs[i].carry, vecs[i].ovf,
             $sformatf("vec%0d", i));

    // Backpressure: result held, extra requests ignored while DONE
    cur_tag = "bp";
    @(negedge clk_i);
    a_i = 64'h0000_0010_0000_0020; b_i = 64'h0000_0001_0000_0002;
    in_valid_i = 1'b1; out_ready_i = 1'b0;
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    got = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      if (out_valid_o) begin
        got = k;
        break;
      end
    end
    chk("latency", 64'(got), 64'd3);
    chk("sum", sum_o, 64'h0000_0011_0000_0022);
    for (int i = 0; i < 10; i++) begin
      a_i = 64'h99 + 64'(i); b_i = 64'h1;
      in_valid_i = (i % 2 == 0);
      @(negedge clk_i);
      chk("hold_valid", 64'(out_valid_o), 64'd1);
      chk("hold_sum",   sum_o,            64'h0000_0011_0000_0022);
      chk("hold_ready", 64'(in_ready_o),  64'd0);
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("rel_valid", 64'(out_valid_o), 64'd0);
    chk("rel_ready", 64'(in_ready_o),  64'd1);
    seen = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (busy_o || out_valid_o) seen = 1;
    end
    chk("no_ghost_op", 64'(seen), 64'd0);

    // Reset asserted while in HI aborts the operation
    cur_tag = "rst_hi";
    @(negedge clk_i);
    a_i = 64'hFFFF_FFFF_FFFF_FFFF; b_i = 64'h1; in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("hi_busy",  64'(busy_o),  64'd1);
    chk("hi_add_a", 64'(add_a_o), 64'hFFFF_FFFF);
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (out_valid_o) seen = 1;
    end
    chk("no_valid_after_rst", 64'(seen), 64'd0);
    run_op(64'd3, 64'd4, 64'd7, 3, 1'b0, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
